tx_buffer: RTL and testbench
============================

TX_BUFFER -- requirements
Module: tx_buffer

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries, power of two, 2..64.
REQ-002 Parameter ADDR_W, default `DATA_MEM_ADDR_SIZE: width of the address port.
REQ-003 Parameter TX_ADDR, default all-ones (ADDR_W bits): data-port address; a write here pushes writeData[7:0].
REQ-004 Parameter STATUS_ADDR, default all-ones minus 1: status/control address.
REQ-005 clk  in  1  single clock, the CPU pipeline clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 address  in  ADDR_W  MEM-stage address from aluResultMEM.
REQ-008 memWriteCPU  in  1  MEM-stage store strobe, one cycle per store.
REQ-009 memReadCPU  in  1  MEM-stage load strobe.
REQ-010 writeData  in  32  store data; only [7:0] is used for pushes.
REQ-011 readData  out  32  status word.
REQ-012 readHit  out  1  readData is valid this cycle (for the load-data mux).
REQ-013 txData  out  8  byte presented to uart txData.
REQ-014 txEnable  out  1  one-cycle start pulse to uart txEnable.
REQ-015 txBusy  in  1  uart tx_busy.
REQ-016 full, empty  out  1 each  FIFO flags.
REQ-017 overflow  out  1  sticky drop flag.

Function
REQ-018 Push: memWriteCPU=1 and address==TX_ADDR. Accepted when not full, or when a pop occurs in the same cycle.
REQ-019 Push while full with no same-cycle pop: byte dropped, FIFO unchanged, overflow set on the next edge.
REQ-020 Count ranges 0..DEPTH and uses a $clog2(DEPTH)+1 bit counter. Read and write pointers wrap modulo DEPTH.
REQ-021 empty = (count==0) and full = (count==DEPTH). Both are combinational from registered state.
REQ-022 Drain FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-023 IDLE: when !empty and !txBusy, pop the head into the txData register and go to START.
REQ-024 START: txEnable=1 for exactly this cycle, then go to WAIT_BUSY.
REQ-025 WAIT_BUSY: stay until txBusy=1, then go to WAIT_DONE. If txBusy stays 0 for 16 cycles, return to IDLE; the byte is considered sent.
REQ-026 WAIT_DONE: stay while txBusy=1; on txBusy=0 go to IDLE.
REQ-027 txData stays stable from START until the FSM re-enters IDLE. txEnable is never asserted outside START.
REQ-028 Minimum latency: push at edge N puts the byte on txData at edge N+1 and asserts txEnable during cycle N+2 (FIFO empty, FSM idle, txBusy=0).
REQ-029 Status read: memReadCPU=1 and address==STATUS_ADDR.
REQ-030 Status read timing: readData and readHit are registered and appear on the next cycle, matching dataMem latency.
REQ-031 readData bit map:
- [0] empty
- [1] full
- [2] overflow
- [3] FSM not IDLE
- [15:8] count
- all other bits 0
REQ-032 A non-matching read gives readHit=0 and readData=0.
REQ-033 Clearing overflow: a write to STATUS_ADDR with writeData[0]=1 clears it. If a dropped push happens in the same cycle, set wins.
REQ-034 Writes to STATUS_ADDR never push, and pushes never affect status except through count and the flags.
REQ-035 Simultaneous push and pop when empty is impossible, because a pop requires !empty at the edge.

Reset
REQ-036 rst=1 at an edge sets:
- pointers=0, count=0, FSM=IDLE
- txData=0, txEnable=0
- overflow=0, readData=0, readHit=0
REQ-037 Flags after reset: empty=1, full=0.
REQ-038 Reset mid-transmission abandons the FIFO contents and the current byte. The block does not wait for txBusy to fall; it re-arms once txBusy=0.
REQ-039 FIFO storage array needs no reset; contents are don't-care while empty.

Structure
REQ-040 Shared constants in parameters.v:
- TX_ADDR and STATUS_ADDR default values
- status bit positions
- FSM state encodings (2 bits)
REQ-041 One sub-module, fifo_sync (DEPTH x 8, push/pop/full/empty/count). The FSM and the address decode stay in tx_buffer.
REQ-042 mips32TOP instantiates tx_buffer beside the arbiter, with txData/txEnable feeding uart0 in place of writeData[7:0]/enableTx0.

Verification
REQ-043 Single byte: reset, store 0x41 to TX_ADDR with txBusy model 10 cycles.
- txData=0x41 at N+1
- one txEnable pulse in cycle N+2
- empty=1 after the pop
REQ-044 Ordering: push 0x01..0x08 back-to-back.
- full=1 after the 8th push
- 8 txEnable pulses with txData 0x01..0x08 in order
- no pulse while txBusy=1
REQ-045 Overflow: hold txBusy=1 and push 9 bytes.
- 9th dropped, overflow=1
- status read returns 0x0806 one cycle after the read strobe
- writing 1 to STATUS_ADDR clears overflow
REQ-046 Full plus simultaneous pop: FIFO full, FSM in IDLE, txBusy falls in the same cycle as a push.
- push accepted, count stays 8
- overflow stays 0
REQ-047 Reset mid-send: assert rst during WAIT_DONE.
- next cycle: count=0, txEnable=0, FSM IDLE
- a following push transmits normally
REQ-048 Timeout: txBusy tied 0, push 0xAA.
- one txEnable pulse, then return to IDLE after 16 cycles
- next byte proceeds

Source files
------------

// File: rtl/tx_buffer_pkg.sv
// Shared constants, drain FSM states and status word packing for tx_buffer.
package tx_buffer_pkg;

  localparam int unsigned DATA_MEM_ADDR_SIZE = 32;

  // Status word bit positions
  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_ACTIVE    = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  // Cycles the drainer waits for the UART to report busy before assuming the byte went out
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } drain_state_e;

  function automatic logic [31:0] status_word(input logic       is_empty,
                                              input logic       is_full,
                                              input logic       ovf,
                                              input logic       active,
                                              input logic [7:0] level);
    logic [31:0] w;
    w                       = '0;
    w[ST_EMPTY]             = is_empty;
    w[ST_FULL]              = is_full;
    w[ST_OVERFLOW]          = ovf;
    w[ST_ACTIVE]            = active;
    w[ST_COUNT_LSB +: 8]    = level;
    return w;
  endfunction

endpackage

// File: rtl/tx_buffer_if.sv
// CPU MEM-stage bus as seen by the tx_buffer peripheral.
interface tx_buffer_if
  import tx_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = DATA_MEM_ADDR_SIZE
);
  logic [ADDR_W-1:0] address;
  logic              memWriteCPU;
  logic              memReadCPU;
  logic [31:0]       writeData;
  logic [31:0]       readData;
  logic              readHit;

  modport master (output address, memWriteCPU, memReadCPU, writeData,
                  input  readData, readHit);
  modport slave  (input  address, memWriteCPU, memReadCPU, writeData,
                  output readData, readHit);
endinterface

// File: rtl/tx_buffer_fifo_sync.sv
// DEPTH x 8 synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
module tx_buffer_fifo_sync
  import tx_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO is only taken when the head leaves on the same edge
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage: contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      count <= count + CNT_W'(1);
      else if (rd_en && !wr_en) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/tx_buffer.sv
// Memory-mapped UART transmit buffer: CPU stores fill a FIFO, a drain FSM feeds the UART.
module tx_buffer
  import tx_buffer_pkg::*;
#(
  parameter int unsigned       DEPTH       = 8,
  parameter int unsigned       ADDR_W      = DATA_MEM_ADDR_SIZE,
  parameter logic [ADDR_W-1:0] TX_ADDR     = '1,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0}
) (
  input  logic           clk,
  input  logic           rst,
  tx_buffer_if.slave     bus,
  output logic [7:0]     txData,
  output logic           txEnable,
  input  logic           txBusy,
  output logic           full,
  output logic           empty,
  output logic           overflow
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  drain_state_e         state;
  drain_state_e         next_state;
  logic [CNT_W-1:0]     count;
  logic [7:0]           head;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 push_req;
  logic                 pop;
  logic                 drop;
  logic                 status_wr;
  logic                 status_rd;

  assign push_req  = bus.memWriteCPU && (bus.address == TX_ADDR);
  assign status_wr = bus.memWriteCPU && (bus.address == STATUS_ADDR);
  assign status_rd = bus.memReadCPU  && (bus.address == STATUS_ADDR);
  assign drop      = push_req && full && !pop;

  tx_buffer_fifo_sync #(.DEPTH(DEPTH)) fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (bus.writeData[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Drain FSM next state, FIFO pop and UART start pulse
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    txEnable   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !txBusy) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        txEnable   = 1'b1;
        next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (txBusy)
          next_state = WAIT_DONE;
        else if (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1))
          next_state = IDLE;
      end
      WAIT_DONE: begin
        if (!txBusy) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counts idle-UART cycles spent in WAIT_BUSY; held at zero elsewhere
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_BUSY) timeout_cnt <= '0;
    else if (!txBusy)              timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
  end

  // Byte register presented to the UART, loaded on each pop
  always_ff @(posedge clk) begin
    if (rst)      txData <= '0;
    else if (pop) txData <= head;
  end

  // Sticky overflow; a drop on the same edge as a clear keeps it set
  always_ff @(posedge clk) begin
    if (rst)                                   overflow <= 1'b0;
    else if (drop)                             overflow <= 1'b1;
    else if (status_wr && bus.writeData[0])    overflow <= 1'b0;
  end

  // Registered status read, one cycle behind the strobe like data memory
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.readHit  <= 1'b0;
      bus.readData <= '0;
    end else begin
      bus.readHit  <= status_rd;
      bus.readData <= status_rd ? status_word(empty, full, overflow, state != IDLE, 8'(count))
                                : '0;
    end
  end
endmodule

// File: tb/tb_tx_buffer.sv
// Self-checking bench for tx_buffer: queue-based model plus directed scenarios.
module tb_tx_buffer;
  localparam int          DEPTH = 8;
  localparam logic [31:0] TXA   = 32'hFFFF_FFFF;
  localparam logic [31:0] STA   = 32'hFFFF_FFFE;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txData;
  logic       txEnable;
  logic       txBusy = 1'b0;
  logic       full, empty, overflow;

  tx_buffer_if #(.ADDR_W(32)) bus();

  tx_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .txData   (txData),
    .txEnable (txEnable),
    .txBusy   (txBusy),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- UART busy model ----------------
  int uart_len  = 10;
  int busy_cnt  = 0;
  bit hold_busy = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (txEnable === 1'b1 && uart_len > 0) busy_cnt = uart_len;
    else if (busy_cnt > 0)                 busy_cnt--;
    txBusy = hold_busy || (busy_cnt > 0);
  end

  // ---------------- Behavioural model ----------------
  // Bytes waiting, whether a byte is in flight, and the phases of its send.
  logic [7:0]  q[$];
  bit          m_valid  = 1'b0;
  bit          m_over   = 1'b0;
  bit          m_active = 1'b0;
  bit          m_pulse  = 1'b0;
  bit          m_seen   = 1'b0;
  int          m_wait   = 0;
  logic [7:0]  m_tx     = 8'h00;
  bit          m_hit    = 1'b0;
  logic [31:0] m_rd     = 32'h0;

  always @(posedge clk) begin : model
    int          sz;
    logic [31:0] st;
    bit          do_pop, preq, drop, clr;
    if (rst) begin
      q.delete();
      m_valid = 1'b1; m_over = 1'b0; m_active = 1'b0; m_pulse = 1'b0;
      m_seen = 1'b0; m_wait = 0; m_tx = 8'h00; m_hit = 1'b0; m_rd = 32'h0;
    end else if (m_valid) begin
      sz = q.size();
      st = 32'h0;
      st[0] = (sz == 0);
      st[1] = (sz == DEPTH);
      st[2] = m_over;
      st[3] = m_active;
      st[15:8] = sz[7:0];
      m_hit = bus.memReadCPU && bus.address == STA;
      m_rd  = m_hit ? st : 32'h0;
      do_pop = !m_active && sz > 0 && !txBusy;
      preq   = bus.memWriteCPU && bus.address == TXA;
      drop   = preq && sz == DEPTH && !do_pop;
      clr    = bus.memWriteCPU && bus.address == STA && bus.writeData[0];
      if (do_pop) begin
        m_tx = q.pop_front(); m_active = 1'b1; m_pulse = 1'b1;
      end else if (m_active) begin
        if (m_pulse) begin
          m_pulse = 1'b0; m_seen = 1'b0; m_wait = 0;
        end else if (!m_seen) begin
          if (txBusy)           m_seen = 1'b1;
          else if (m_wait == 15) m_active = 1'b0;
          else                   m_wait++;
        end else if (!txBusy) begin
          m_active = 1'b0;
        end
      end
      if (preq && !drop) q.push_back(bus.writeData[7:0]);
      m_over = drop ? 1'b1 : (clr ? 1'b0 : m_over);
    end
  end

  // ---------------- Per-cycle compare ----------------
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (m_valid) begin
      check("empty",    32'(empty),        32'(q.size() == 0));
      check("full",     32'(full),         32'(q.size() == DEPTH));
      check("overflow", 32'(overflow),     32'(m_over));
      check("txEnable", 32'(txEnable),     32'(m_pulse));
      check("txData",   32'(txData),       32'(m_tx));
      check("readHit",  32'(bus.readHit),  32'(m_hit));
      check("readData", bus.readData,      m_rd);
      if (txEnable === 1'b1) begin
        got.push_back(txData);
        check("pulse_while_busy", 32'(txBusy), 32'h0);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    bus.address = TXA; bus.writeData = {24'h0, b}; bus.memWriteCPU = 1'b1;
    tick();
    bus.memWriteCPU = 1'b0;
  endtask

  task automatic wr_status(input logic [31:0] d);
    bus.address = STA; bus.writeData = d; bus.memWriteCPU = 1'b1;
    tick();
    bus.memWriteCPU = 1'b0;
  endtask

  task automatic read_addr(input logic [31:0] a);
    bus.address = a; bus.memReadCPU = 1'b1;
    tick();
    bus.memReadCPU = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(q.size() == 0 && !m_active && busy_cnt == 0) && n < max) begin
      tick(); n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL wait_idle actual=timeout required=idle within %0d cycles", max);
    end
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = 0;
    while (txEnable !== 1'b1 && n < max) begin
      tick(); n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL wait_pulse actual=no pulse required=pulse within %0d cycles", max);
    end
  endtask

  task automatic check_seq(input string name, input int base, input logic [7:0] exp[$]);
    check({name, "_len"}, 32'(got.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < got.size(); i++)
      check(name, 32'(got[base + i]), 32'(exp[i]));
  endtask

  // ---------------- Directed scenarios ----------------
  initial begin
    int         base, n;
    logic [7:0] exp[$];

    rst = 1'b1;
    bus.address = '0; bus.writeData = '0; bus.memWriteCPU = 1'b0; bus.memReadCPU = 1'b0;
    tick(); tick();
    check("rst_empty",    32'(empty),       32'h1);
    check("rst_full",     32'(full),        32'h0);
    check("rst_overflow", 32'(overflow),    32'h0);
    check("rst_txEnable", 32'(txEnable),    32'h0);
    check("rst_txData",   32'(txData),      32'h0);
    check("rst_readHit",  32'(bus.readHit), 32'h0);
    check("rst_readData", bus.readData,     32'h0);
    rst = 1'b0;

    // Single byte, minimum latency
    uart_len = 10;
    push(8'h41);
    check("single_count1",   32'(empty),    32'h0);
    check("single_noenable", 32'(txEnable), 32'h0);
    tick();
    check("single_txData",   32'(txData),   32'h41);
    check("single_txEnable", 32'(txEnable), 32'h1);
    check("single_empty",    32'(empty),    32'h1);
    tick();
    check("single_pulse_end", 32'(txEnable), 32'h0);
    wait_idle(100);

    // Ordering: fill while UART busy, then drain in order
    uart_len = 4;
    hold_busy = 1'b1;
    base = got.size();
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("order_full", 32'(full), 32'h1);
    hold_busy = 1'b0;
    wait_idle(300);
    exp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_seq("order_data", base, exp);

    // Overflow: 9 pushes with UART held busy
    hold_busy = 1'b1;
    base = got.size();
    for (int i = 0; i < 9; i++) begin
      push(8'(8'h10 + i));
      if (i == 7) check("ovf_full8", 32'(full), 32'h1);
    end
    check("ovf_set", 32'(overflow), 32'h1);
    read_addr(STA);
    check("ovf_status_hit",  32'(bus.readHit), 32'h1);
    check("ovf_status_word", bus.readData,     32'h0000_0806);
    read_addr(TXA);
    check("nomatch_hit",  32'(bus.readHit), 32'h0);
    check("nomatch_data", bus.readData,     32'h0);
    wr_status(32'h1);
    check("ovf_cleared",      32'(overflow), 32'h0);
    check("status_wr_nopush", 32'(full),     32'h1);

    // Full plus simultaneous pop: UART frees up on the same edge as a push
    hold_busy = 1'b0;
    push(8'h19);
    check("fullpop_full", 32'(full),     32'h1);
    check("fullpop_ovf",  32'(overflow), 32'h0);
    read_addr(STA);
    check("fullpop_status", bus.readData, 32'h0000_080A);
    uart_len = 3;
    wait_idle(300);
    exp = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h19};
    check_seq("ovf_data", base, exp);

    // Reset during WAIT_DONE
    uart_len = 20;
    push(8'h55); push(8'h56); push(8'h57);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_empty",    32'(empty),    32'h1);
    check("midrst_txEnable", 32'(txEnable), 32'h0);
    check("midrst_ovf",      32'(overflow), 32'h0);
    read_addr(STA);
    check("midrst_status", bus.readData, 32'h0000_0001);
    push(8'h66);
    wait_pulse(60, n);
    check("midrst_next_data", 32'(txData), 32'h66);
    wait_idle(100);

    // Timeout: UART never reports busy
    uart_len = 0;
    push(8'hAA);
    tick();
    check("tmo_txEnable", 32'(txEnable), 32'h1);
    check("tmo_txData",   32'(txData),   32'hAA);
    push(8'hBB);
    wait_pulse(40, n);
    check("tmo_gap",       32'(n + 1), 32'd18);
    check("tmo_next_data", 32'(txData), 32'hBB);
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
